barrel_shifter_pipe: RTL and testbench
======================================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have parameter AMT_W, default 8, giving the shift-amount width; AMT_W SHALL be at least $clog2(WIDTH)+1.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 in_valid  in  1  input operation present.
REQ-006 in_ready  out  1  block accepts an operation this cycle.
REQ-007 in_data  in  WIDTH  operand.
REQ-008 in_amt  in  AMT_W  unsigned shift amount.
REQ-009 in_mode  in  3  operation: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101 ROL; 110 and 111 pass the operand through.
REQ-010 in_cin  in  1  carry-in, the C flag.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out_data  out  WIDTH  result.
REQ-014 out_cout  out  1  shifter carry-out.

Function
REQ-015 An operation SHALL be accepted only on a cycle where in_valid and in_ready are both high.
REQ-016 A result SHALL be consumed only on a cycle where out_valid and out_ready are both high.
REQ-017 The block SHALL be a two-stage pipeline:
- stage 1 registers the operands and the decoded amount class (zero, in range, equal to WIDTH, above WIDTH) plus the rotate amount mod WIDTH;
- stage 2 registers out_data and out_cout.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to out_valid when the block is not stalled, with throughput of one operation per cycle.
REQ-019 Stall rules:
- stage 2 loads when it is empty or out_ready is high;
- stage 1 advances when stage 2 loads;
- in_ready SHALL equal (stage 1 empty) OR (stage 1 advances), combinationally.
REQ-020 While out_valid is high and out_ready is low, out_data and out_cout SHALL hold stable.
REQ-021 For any amount of 0 in LSL, LSR, ASR, ROR or ROL, the result SHALL be in_data and cout SHALL be in_cin.
REQ-022 LSL, amount n: for 1 ≤ n < WIDTH, data = in<<n and cout = in[WIDTH-n]; for n = WIDTH, data = 0 and cout = in[0]; for n > WIDTH, data = 0 and cout = 0.
REQ-023 LSR, amount n: for 1 ≤ n < WIDTH, data = in>>n and cout = in[n-1]; for n = WIDTH, data = 0 and cout = in[WIDTH-1]; for n > WIDTH, data = 0 and cout = 0.
REQ-024 ASR, amount n: for 1 ≤ n < WIDTH, sign-fill shift with cout = in[n-1]; for n ≥ WIDTH, data = all bits equal to in[WIDTH-1] and cout = in[WIDTH-1].
REQ-025 ROR, nonzero amount: rotate right by (n mod WIDTH) and cout = data[WIDTH-1]; a multiple of WIDTH SHALL return data unchanged with cout = in[WIDTH-1].
REQ-026 ROL, nonzero amount: rotate left by (n mod WIDTH) and cout = data[0]; this is the generalised legacy 8-bit rotator.
REQ-027 RRX SHALL ignore in_amt and produce data = {cin, in[WIDTH-1:1]} with cout = in[0].
REQ-028 Modes 110 and 111 SHALL produce data = in and cout = in_cin.
REQ-029 Simultaneous acceptance and consumption SHALL lose and duplicate no operation.

Reset
REQ-030 While rst is high, both stage-valid flags SHALL clear immediately; out_valid SHALL be 0, out_data SHALL be 0, out_cout SHALL be 0, and in_ready SHALL be 1 once rst deasserts.
REQ-031 An operation in flight when reset asserts SHALL be discarded and never presented.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst falls.

Structure
REQ-033 A shared package shifter_pkg SHALL hold:
- the shift_mode_e enum for the 3-bit in_mode;
- the amount-class enum.
REQ-034 The combinational shift core SHALL be a sub-module named shift_core, instantiated between stage 1 and stage 2, with no state of its own.

Verification
REQ-035 Reset mid-flight: accept two operations, assert rst on the next cycle → out_valid stays 0 and no result ever appears.
REQ-036 Back-to-back streaming: out_ready held 1 with LSL 0x0000_0001 by 4, then LSR 0x8000_0000 by 32 → results 0x0000_0010/cout 0, then 0x0000_0000/cout 1, on consecutive cycles starting 2 cycles after the first acceptance.
REQ-037 ASR 0x8000_0000 by 40 → data 0xFFFF_FFFF, cout 1.
REQ-038 ROR 0x0000_00F1 by 36 → data 0x1000_000F, cout 0.
REQ-039 RRX 0x0000_0003 with cin 1 → data 0x8000_0001, cout 1.
REQ-040 Backpressure: out_ready held 0 for 5 cycles with in_valid always 1 → exactly 2 operations accepted, in_ready low afterwards, out_data stable; on out_ready release, results drain in order.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Operation encodings and the decoded shift-amount class.
package shifter_pkg;

   typedef enum logic [2:0] {
      MODE_LSL   = 3'b000,
      MODE_LSR   = 3'b001,
      MODE_ASR   = 3'b010,
      MODE_ROR   = 3'b011,
      MODE_RRX   = 3'b100,
      MODE_ROL   = 3'b101,
      MODE_PASS0 = 3'b110,
      MODE_PASS1 = 3'b111
   } shift_mode_e;

   typedef enum logic [1:0] {
      AMT_ZERO  = 2'd0,
      AMT_IN    = 2'd1,
      AMT_EQ    = 2'd2,
      AMT_ABOVE = 2'd3
   } amt_class_e;

endpackage

// File: rtl/shift_core.sv
// Combinational shift/rotate datapath with carry-out.
// Consumes the amount class decoded in stage 1.
module shift_core
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   input  logic             cin,
   input  shift_mode_e      mode,
   input  amt_class_e       cls,
   input  logic [LW-1:0]    amt,
   output logic [WIDTH-1:0] res,
   output logic             cout
);

   logic [WIDTH:0]     lsl_x;
   logic [WIDTH:0]     lsr_x;
   logic [WIDTH:0]     asr_x;
   logic [2*WIDTH-1:0] ror_x;
   logic [2*WIDTH-1:0] rol_x;
   logic               sign;

   // An extra guard bit carries the last bit shifted out.
   assign lsl_x = {1'b0, data} << amt;
   assign lsr_x = {data, 1'b0} >> amt;
   assign asr_x = $signed({data, 1'b0}) >>> amt;
   assign ror_x = {data, data} >> amt;
   assign rol_x = {data, data} << amt;
   assign sign  = data[WIDTH-1];

   // Select result and carry by mode and amount class.
   always_comb begin
      res  = data;
      cout = cin;
      case (mode)
         MODE_LSL: begin
            case (cls)
               AMT_IN:    begin res = lsl_x[WIDTH-1:0]; cout = lsl_x[WIDTH]; end
               AMT_EQ:    begin res = '0; cout = data[0]; end
               AMT_ABOVE: begin res = '0; cout = 1'b0; end
               default:   ;
            endcase
         end
         MODE_LSR: begin
            case (cls)
               AMT_IN:    begin res = lsr_x[WIDTH:1]; cout = lsr_x[0]; end
               AMT_EQ:    begin res = '0; cout = data[WIDTH-1]; end
               AMT_ABOVE: begin res = '0; cout = 1'b0; end
               default:   ;
            endcase
         end
         MODE_ASR: begin
            case (cls)
               AMT_IN:  begin res = asr_x[WIDTH:1]; cout = asr_x[0]; end
               AMT_EQ,
               AMT_ABOVE: begin res = {WIDTH{sign}}; cout = sign; end
               default: ;
            endcase
         end
         // A multiple of WIDTH rotates by zero, leaving carry = msb.
         MODE_ROR: begin
            if (cls != AMT_ZERO) begin
               res  = ror_x[WIDTH-1:0];
               cout = ror_x[WIDTH-1];
            end
         end
         MODE_ROL: begin
            if (cls != AMT_ZERO) begin
               res  = rol_x[2*WIDTH-1:WIDTH];
               cout = rol_x[WIDTH];
            end
         end
         MODE_RRX: begin
            res  = {cin, data[WIDTH-1:1]};
            cout = data[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Two-stage valid/ready barrel shifter.
// Stage 1 holds operands and amount class; stage 2 holds the result.
module barrel_shifter_pipe
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [2:0]       in_mode,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_cout
);

   localparam int LW = $clog2(WIDTH);
   localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic             s1_cin;
   shift_mode_e      s1_mode;
   amt_class_e       s1_cls;
   logic [LW-1:0]    s1_amt;

   amt_class_e       cls_d;
   logic             s2_load;
   logic             accept;
   logic [WIDTH-1:0] core_res;
   logic             core_cout;

   assign s2_load = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_load;
   assign accept = in_valid && in_ready;

   // Classify the raw amount against the data width.
   always_comb begin
      if (in_amt == '0)
         cls_d = AMT_ZERO;
      else if (in_amt < W_AMT)
         cls_d = AMT_IN;
      else if (in_amt == W_AMT)
         cls_d = AMT_EQ;
      else
         cls_d = AMT_ABOVE;
   end

   // Stage 1: capture operands on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_cin   <= 1'b0;
         s1_mode  <= MODE_LSL;
         s1_cls   <= AMT_ZERO;
         s1_amt   <= '0;
      end else begin
         if (in_ready)
            s1_valid <= in_valid;
         if (accept) begin
            s1_data <= in_data;
            s1_cin  <= in_cin;
            s1_mode <= shift_mode_e'(in_mode);
            s1_cls  <= cls_d;
            s1_amt  <= in_amt[LW-1:0];
         end
      end
   end

   shift_core #(
      .WIDTH (WIDTH),
      .LW    (LW)
   ) u_core (
      .data (s1_data),
      .cin  (s1_cin),
      .mode (s1_mode),
      .cls  (s1_cls),
      .amt  (s1_amt),
      .res  (core_res),
      .cout (core_cout)
   );

   // Stage 2: register the result; hold while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_cout  <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= core_res;
            out_cout <= core_cout;
         end
      end
   end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed self-checking bench for barrel_shifter_pipe.
// Inputs change and outputs are sampled on the falling edge.
module tb_barrel_shifter_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [7:0]  in_amt;
   logic [2:0]  in_mode;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_cout;

   int n_assert;
   int n_fail;
   int nacc;

   barrel_shifter_pipe #(
      .WIDTH (32),
      .AMT_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_cout  (out_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] d, input logic [7:0] a,
                        input logic [2:0] m, input logic c);
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
      in_cin   = c;
   endtask

   // Single operation with out_ready high; result checked 2 cycles later.
   task automatic op(input string tag, input logic [31:0] d,
                     input logic [7:0] a, input logic [2:0] m,
                     input logic c, input logic [31:0] ed,
                     input logic ec);
      @(negedge clk);
      drive(d, a, m, c);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_early"}, {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_data"}, {32'd0, out_data}, {32'd0, ed});
      chk({tag, "_cout"}, {63'd0, out_cout}, {63'd0, ec});
   endtask

   initial begin
      n_assert = 0;
      n_fail = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_amt = '0;
      in_mode = '0;
      in_cin = 1'b0;
      out_ready = 1'b1;

      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
      chk("rst_out_cout", {63'd0, out_cout}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Back-to-back streaming
      @(negedge clk);
      drive(32'h0000_0001, 8'd4, 3'b000, 1'b0);
      @(negedge clk);
      drive(32'h8000_0000, 8'd32, 3'b001, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stream_a_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_a_data", {32'd0, out_data}, 64'h10);
      chk("stream_a_cout", {63'd0, out_cout}, 64'd0);
      @(negedge clk);
      chk("stream_b_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_b_data", {32'd0, out_data}, 64'h0);
      chk("stream_b_cout", {63'd0, out_cout}, 64'd1);
      @(negedge clk);
      chk("stream_drained", {63'd0, out_valid}, 64'd0);

      op("asr40", 32'h8000_0000, 8'd40, 3'b010, 1'b0, 32'hFFFF_FFFF, 1'b1);
      op("ror36", 32'h0000_00F1, 8'd36, 3'b011, 1'b0, 32'h1000_000F, 1'b0);
      op("rrx", 32'h0000_0003, 8'd9, 3'b100, 1'b1, 32'h8000_0001, 1'b1);
      op("rol1", 32'h8000_0001, 8'd1, 3'b101, 1'b0, 32'h0000_0003, 1'b1);
      op("lsl0", 32'h8000_0000, 8'd0, 3'b000, 1'b1, 32'h8000_0000, 1'b1);
      op("lsl32", 32'h0000_0001, 8'd32, 3'b000, 1'b0, 32'h0, 1'b1);
      op("lsl33", 32'hFFFF_FFFF, 8'd33, 3'b000, 1'b1, 32'h0, 1'b0);
      op("lsl31", 32'h0000_0003, 8'd31, 3'b000, 1'b0, 32'h8000_0000, 1'b1);
      op("lsr2", 32'h0000_0006, 8'd2, 3'b001, 1'b0, 32'h0000_0001, 1'b1);
      op("lsr40", 32'hFFFF_FFFF, 8'd40, 3'b001, 1'b1, 32'h0, 1'b0);
      op("asr4", 32'h8000_0000, 8'd4, 3'b010, 1'b1, 32'hF800_0000, 1'b0);
      op("asr32p", 32'h7FFF_FFFF, 8'd32, 3'b010, 1'b1, 32'h0, 1'b0);
      op("ror64", 32'h9234_5678, 8'd64, 3'b011, 1'b0, 32'h9234_5678, 1'b1);
      op("ror0", 32'h9234_5678, 8'd0, 3'b011, 1'b0, 32'h9234_5678, 1'b0);
      op("rol36", 32'h1000_000F, 8'd36, 3'b101, 1'b0, 32'h0000_00F1, 1'b1);
      op("pass6", 32'hDEAD_BEEF, 8'd5, 3'b110, 1'b0, 32'hDEAD_BEEF, 1'b0);
      op("pass7", 32'h1234_5678, 8'd1, 3'b111, 1'b1, 32'h1234_5678, 1'b1);

      // Backpressure: two ops fill the pipe, then in_ready drops
      @(negedge clk);
      out_ready = 1'b0;
      nacc = 0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         if (c >= 2) begin
            chk("bp_hold_data", {32'd0, out_data}, 64'h2);
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         end
         drive(32'(nacc + 1), 8'd1, 3'b000, 1'b0);
         if (in_ready) nacc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_accepted", 64'(nacc), 64'd2);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_stable", {32'd0, out_data}, 64'h2);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_drain2_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_drain2_data", {32'd0, out_data}, 64'h4);
      @(negedge clk);
      chk("bp_drained", {63'd0, out_valid}, 64'd0);

      // Reset mid-flight discards both operations
      @(negedge clk);
      drive(32'h0000_0001, 8'd1, 3'b000, 1'b0);
      @(negedge clk);
      drive(32'h0000_0002, 8'd1, 3'b000, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_data", {32'd0, out_data}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mid_rst_no_out", {63'd0, out_valid}, 64'd0);
      end

      // First acceptance right after reset release
      op("post_rst", 32'h0000_00FF, 8'd4, 3'b001, 1'b0, 32'h0000_000F, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
